// File: rtl/tx_arb_pkg.sv
// rtl/tx_arb_pkg.sv - shared types and limits for the tx_arbiter slice
// Contents: tx_arb_state_t (IDLE, ARM, WAIT), MAX_REQ (upper bound on NUM_REQ).
package tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        WAIT = 2'd2
    } tx_arb_state_t;

    localparam int MAX_REQ = 8;

endpackage

// File: rtl/tx_arbiter_if.sv
// rtl/tx_arbiter_if.sv - requester and UART-wrapper handshake bundle for tx_arbiter
// Signals: req/req_data/gnt (requester side), trmt/resp/tx_done (UART wrapper side).
// Modports: master = arbiter, slave = requesters plus UART wrapper.
interface tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   gnt;
    logic                 trmt;
    logic [7:0]           resp;
    logic                 tx_done;

    modport master (
        input  req, req_data, tx_done,
        output gnt, trmt, resp
    );

    modport slave (
        output req, req_data, tx_done,
        input  gnt, trmt, resp
    );
endinterface

// File: rtl/tx_arbiter_rr_pick.sv
// rtl/tx_arbiter_rr_pick.sv - combinational round-robin picker (module rr_pick)
// Ports: req (request vector), ptr (last granted index),
//        valid (any request), sel (one-hot winner, searching from ptr+1 upward).
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       valid,
    output logic [NUM_REQ-1:0]         sel
);
    localparam int PW = $clog2(NUM_REQ);

    // One extra bit so ptr+offset can exceed NUM_REQ-1 before wrapping.
    logic [PW:0] idx;

    always_comb begin
        valid = 1'b0;
        sel   = '0;
        idx   = '0;
        // Offset NUM_REQ wraps back to ptr itself, so the last winner is tried last.
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = {1'b0, ptr} + (PW+1)'(i);
            if (idx >= (PW+1)'(NUM_REQ)) begin
                idx = idx - (PW+1)'(NUM_REQ);
            end
            if (!valid && req[idx[PW-1:0]]) begin
                valid              = 1'b1;
                sel[idx[PW-1:0]]   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/tx_arbiter.sv
// rtl/tx_arbiter.sv - round-robin arbiter sharing one UART transmit path among NUM_REQ sources
// Ports: clk, rst (sync, active-high), bus (tx_arbiter_if.master: req/req_data/gnt,
//        trmt/resp/tx_done), busy (ARM or WAIT), err (timeout abort pulse).
// Optional feature: TX_ARB_TIMEOUT_EN enables the TIMEOUT_CYC wait limit; otherwise err is 0.
module tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic          clk,
    input  logic          rst,
    tx_arbiter_if.master  bus,
    output logic          busy,
    output logic          err
);
    import tx_arb_pkg::*;

    localparam int PW = $clog2(NUM_REQ);

    tx_arb_state_t        state, state_nx;
    logic [PW-1:0]        ptr, ptr_nx, pick_idx;
    logic [NUM_REQ-1:0]   gnt_q, gnt_nx, pick_sel;
    logic [7:0]           resp_q, resp_nx, pick_byte;
    logic                 trmt_q, trmt_nx, pick_valid;

`ifdef TX_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0]        cnt, cnt_nx;
    logic                 err_q, err_nx;
`endif

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .valid (pick_valid),
        .sel   (pick_sel)
    );

    // Turn the one-hot winner into an index for ptr and a byte for resp.
    always_comb begin
        pick_idx  = '0;
        pick_byte = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_sel[i]) begin
                pick_idx  = PW'(i);
                pick_byte = bus.req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        resp_nx  = resp_q;
        gnt_nx   = '0;
        trmt_nx  = 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
        cnt_nx   = cnt;
        err_nx   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nx = ARM;
                    ptr_nx   = pick_idx;
                    resp_nx  = pick_byte;
                    gnt_nx   = pick_sel;
                    trmt_nx  = 1'b1;
                end
            end
            // tx_done may still be high from the previous frame; it is not looked at here.
            ARM: begin
                state_nx = WAIT;
`ifdef TX_ARB_TIMEOUT_EN
                cnt_nx   = '0;
`endif
            end
            WAIT: begin
                if (bus.tx_done) begin
                    state_nx = IDLE;
`ifdef TX_ARB_TIMEOUT_EN
                end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                    // This WAIT cycle is the TIMEOUT_CYC-th one: give up on the frame.
                    state_nx = IDLE;
                    err_nx   = 1'b1;
                end else begin
                    cnt_nx   = cnt + CW'(1);
`endif
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= PW'(NUM_REQ - 1);
            gnt_q  <= '0;
            trmt_q <= 1'b0;
            resp_q <= 8'h00;
        end else begin
            state  <= state_nx;
            ptr    <= ptr_nx;
            gnt_q  <= gnt_nx;
            trmt_q <= trmt_nx;
            resp_q <= resp_nx;
        end
    end

`ifdef TX_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            cnt   <= cnt_nx;
            err_q <= err_nx;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign bus.gnt  = gnt_q;
    assign bus.trmt = trmt_q;
    assign bus.resp = resp_q;
    assign busy     = (state == ARM) || (state == WAIT);
endmodule
